// File: rtl/gpr_read_sequencer.sv
// Operand read sequencer: reads rs1/rs2/rs3 for one instruction through a single
// synchronous GPR read port and presents the collected set with valid/ready.
module gpr_read_sequencer #(
    parameter int NUM_THREADS = 4,
    parameter int NUM_WARPS   = 4,
    parameter int NUM_REGS    = 32,
    parameter int TAG_WIDTH   = 8,
    localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int RW = $clog2(NUM_REGS),
    localparam int DW = NUM_THREADS * 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WW-1:0]        req_wid,
    input  logic [RW-1:0]        req_rs1,
    input  logic [RW-1:0]        req_rs2,
    input  logic [RW-1:0]        req_rs3,
    input  logic                 req_use_rs3,
    input  logic [TAG_WIDTH-1:0] req_tag,
    output logic                 gpr_rd_en,
    output logic [WW+RW-1:0]     gpr_rd_addr,
    input  logic [DW-1:0]        gpr_rd_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WW-1:0]        rsp_wid,
    output logic [TAG_WIDTH-1:0] rsp_tag,
    output logic [DW-1:0]        rs1_data,
    output logic [DW-1:0]        rs2_data,
    output logic [DW-1:0]        rs3_data
);

    typedef enum logic [1:0] {IDLE, READ, CAPT, RSP} state_t;

    state_t        state, state_nxt;
    logic [RW-1:0] rs1_q, rs2_q, rs3_q;
    logic [2:0]    pend_q;       // operands still to be read, bit0 = rs1
    logic [1:0]    prev_op_q;    // operand whose read data arrives this cycle
    logic          prev_vld_q;
    logic [1:0]    sel;
    logic [2:0]    pend_after;
    logic [RW-1:0] sel_reg;
    logic [2:0]    need;
    logic          accept;

    // x0 is hardwired zero, so it never costs a port access.
    assign need   = {req_use_rs3 && (req_rs3 != '0), req_rs2 != '0, req_rs1 != '0};
    assign accept = req_valid && req_ready;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        sel        = 2'd2;
        pend_after = pend_q;
        sel_reg    = rs3_q;
        if (pend_q[0]) begin
            sel        = 2'd0;
            pend_after = {pend_q[2:1], 1'b0};
            sel_reg    = rs1_q;
        end else if (pend_q[1]) begin
            sel        = 2'd1;
            pend_after = {pend_q[2], 2'b00};
            sel_reg    = rs2_q;
        end else begin
            pend_after = 3'b000;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (need == 3'b000) ? RSP : READ;
            READ: if (pend_after == 3'b000) state_nxt = CAPT;
            CAPT: state_nxt = RSP;
            RSP:  if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = (state == IDLE) && !reset;
        gpr_rd_en   = (state == READ) && !reset;
        rsp_valid   = (state == RSP) && !reset;
        gpr_rd_addr = gpr_rd_en ? {rsp_wid, sel_reg} : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_wid    <= '0;
            rsp_tag    <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs3_q      <= '0;
            pend_q     <= '0;
            prev_op_q  <= '0;
            prev_vld_q <= 1'b0;
            rs1_data   <= '0;
            rs2_data   <= '0;
            rs3_data   <= '0;
        end else if (accept) begin
            rsp_wid    <= req_wid;
            rsp_tag    <= req_tag;
            rs1_q      <= req_rs1;
            rs2_q      <= req_rs2;
            rs3_q      <= req_rs3;
            pend_q     <= need;
            prev_vld_q <= 1'b0;
            rs1_data   <= '0;
            rs2_data   <= '0;
            rs3_data   <= '0;
        end else begin
            if ((state == READ || state == CAPT) && prev_vld_q) begin
                case (prev_op_q)
                    2'd0:    rs1_data <= gpr_rd_data;
                    2'd1:    rs2_data <= gpr_rd_data;
                    default: rs3_data <= gpr_rd_data;
                endcase
            end
            if (state == READ) begin
                prev_vld_q <= 1'b1;
                prev_op_q  <= sel;
                pend_q     <= pend_after;
            end else begin
                prev_vld_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gpr_read_sequencer.sv
// Directed bench for gpr_read_sequencer with a one-cycle-latency GPR RAM model.
module tb_gpr_read_sequencer;

    localparam int DW = 128;

    logic           clk = 1'b0;
    logic           reset;
    logic           req_valid;
    logic           req_ready;
    logic [1:0]     req_wid;
    logic [4:0]     req_rs1, req_rs2, req_rs3;
    logic           req_use_rs3;
    logic [7:0]     req_tag;
    logic           gpr_rd_en;
    logic [6:0]     gpr_rd_addr;
    logic [DW-1:0]  gpr_rd_data;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_wid;
    logic [7:0]     rsp_tag;
    logic [DW-1:0]  rs1_data, rs2_data, rs3_data;

    int checks   = 0;
    int failures = 0;

    gpr_read_sequencer dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wid(req_wid),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3),
        .req_use_rs3(req_use_rs3), .req_tag(req_tag),
        .gpr_rd_en(gpr_rd_en), .gpr_rd_addr(gpr_rd_addr), .gpr_rd_data(gpr_rd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wid(rsp_wid), .rsp_tag(rsp_tag),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rs3_data(rs3_data)
    );

    always #5 clk = ~clk;

    // Each lane word encodes lane number and address so misrouted data is visible.
    function automatic logic [DW-1:0] pat(input logic [6:0] a);
        logic [DW-1:0] r;
        for (int l = 0; l < 4; l++) r[l*32 +: 32] = {8'(l), 8'h5A, 9'd0, a};
        return r;
    endfunction

    // Junk on idle cycles catches captures from the wrong cycle.
    always @(posedge clk) begin
        if (gpr_rd_en) gpr_rd_data <= pat(gpr_rd_addr);
        else           gpr_rd_data <= {4{32'hDEADBEEF}};
    end

    task automatic chk(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [1:0] wid, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] r3, input logic u3, input logic [7:0] tag,
                          input int exp_n, input int hold);
        logic [6:0]    addrs[3];
        int            k;
        logic [DW-1:0] e1, e2, e3;
        k = 0;
        if (r1 != 0) begin addrs[k] = {wid, r1}; k++; end
        if (r2 != 0) begin addrs[k] = {wid, r2}; k++; end
        if (u3 && r3 != 0) begin addrs[k] = {wid, r3}; k++; end
        e1 = (r1 != 0) ? pat({wid, r1}) : '0;
        e2 = (r2 != 0) ? pat({wid, r2}) : '0;
        e3 = (u3 && r3 != 0) ? pat({wid, r3}) : '0;

        req_valid = 1'b1; req_wid = wid; req_rs1 = r1; req_rs2 = r2; req_rs3 = r3;
        req_use_rs3 = u3; req_tag = tag;
        #1;
        chk("req_ready_idle", DW'(req_ready), DW'(1));
        cycle();
        req_valid = 1'b0;
        for (int i = 0; i < exp_n; i++) begin
            chk($sformatf("rd_en_%0d", i), DW'(gpr_rd_en), DW'(1));
            chk($sformatf("rd_addr_%0d", i), DW'(gpr_rd_addr), DW'(addrs[i]));
            chk("rsp_valid_early", DW'(rsp_valid), DW'(0));
            cycle();
        end
        if (exp_n > 0) begin
            chk("capt_rd_en", DW'(gpr_rd_en), DW'(0));
            chk("capt_rd_addr", DW'(gpr_rd_addr), DW'(0));
            chk("capt_rsp_valid", DW'(rsp_valid), DW'(0));
            cycle();
        end
        for (int h = 0; h <= hold; h++) begin
            chk("rsp_valid", DW'(rsp_valid), DW'(1));
            chk("rsp_req_ready", DW'(req_ready), DW'(0));
            chk("rsp_rd_en", DW'(gpr_rd_en), DW'(0));
            chk("rsp_wid", DW'(rsp_wid), DW'(wid));
            chk("rsp_tag", DW'(rsp_tag), DW'(tag));
            chk("rs1_data", rs1_data, e1);
            chk("rs2_data", rs2_data, e2);
            chk("rs3_data", rs3_data, e3);
            if (h < hold) cycle();
        end
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;
        #1;
        chk("post_rsp_valid", DW'(rsp_valid), DW'(0));
        chk("post_req_ready", DW'(req_ready), DW'(1));
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_wid = '0; req_rs1 = '0; req_rs2 = '0;
        req_rs3 = '0; req_use_rs3 = 1'b0; req_tag = '0; rsp_ready = 1'b0;
        cycle(); cycle();
        chk("rst_req_ready", DW'(req_ready), DW'(0));
        chk("rst_rd_en", DW'(gpr_rd_en), DW'(0));
        chk("rst_rd_addr", DW'(gpr_rd_addr), DW'(0));
        chk("rst_rsp_valid", DW'(rsp_valid), DW'(0));
        chk("rst_rsp_wid", DW'(rsp_wid), DW'(0));
        chk("rst_rsp_tag", DW'(rsp_tag), DW'(0));
        chk("rst_rs1", rs1_data, '0);
        chk("rst_rs2", rs2_data, '0);
        chk("rst_rs3", rs3_data, '0);
        reset = 1'b0;
        #1;
        chk("idle_req_ready", DW'(req_ready), DW'(1));
        cycle();

        // rsp_ready while idle must be ignored.
        rsp_ready = 1'b1;
        cycle();
        chk("idle_rsp_ready_ignored", DW'(rsp_valid), DW'(0));
        rsp_ready = 1'b0;

        do_req(2'd2, 5'd5, 5'd7, 5'd0, 1'b0, 8'h3C, 2, 0);
        do_req(2'd1, 5'd1, 5'd2, 5'd3, 1'b1, 8'h11, 3, 0);
        do_req(2'd3, 5'd0, 5'd0, 5'd5, 1'b0, 8'hA5, 0, 0);
        do_req(2'd0, 5'd0, 5'd9, 5'd0, 1'b1, 8'h42, 1, 0);
        do_req(2'd2, 5'd4, 5'd4, 5'd31, 1'b1, 8'hE1, 3, 5);
        do_req(2'd3, 5'd31, 5'd6, 5'd0, 1'b0, 8'h5F, 2, 0);

        // Abort in READ after the first read has been issued.
        req_valid = 1'b1; req_wid = 2'd1; req_rs1 = 5'd1; req_rs2 = 5'd2;
        req_rs3 = 5'd3; req_use_rs3 = 1'b1; req_tag = 8'h77;
        cycle();
        req_valid = 1'b0;
        chk("abort_rd_en", DW'(gpr_rd_en), DW'(1));
        chk("abort_rd_addr", DW'(gpr_rd_addr), DW'({2'd1, 5'd1}));
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        chk("abort_rsp_valid", DW'(rsp_valid), DW'(0));
        chk("abort_rd_en_off", DW'(gpr_rd_en), DW'(0));
        chk("abort_req_ready", DW'(req_ready), DW'(1));
        chk("abort_rs1_cleared", rs1_data, '0);
        do_req(2'd3, 5'd2, 5'd1, 5'd0, 1'b0, 8'h78, 2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpr_read_sequencer.md
Name: gpr_read_sequencer

Overview:
- Sequences operand reads for one issued instruction through a single synchronous read port of the warp GPR bank.
- Reads rs1, rs2 and optionally rs3 for all NUM_THREADS lanes, one register per cycle, and collects them into output registers.
- Presents the collected rs1/rs2/rs3 data set to the dispatch stage with a valid/ready handshake.
- Sits between the issue/scoreboard stage and the GPR RAM; the only requester of that read port.

Parameters:
NUM_THREADS, 4, lanes per warp; each data bus is NUM_THREADS*32 bits
NUM_WARPS, 4, warps sharing the bank; WW = max(1, clog2(NUM_WARPS))
NUM_REGS, 32, registers per warp; RW = clog2(NUM_REGS)
TAG_WIDTH, 8, opaque request tag carried to the response

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  1  operand read request
req_ready  out  1  request accepted when high with req_valid
req_wid  in  WW  warp id
req_rs1  in  RW  source register 1
req_rs2  in  RW  source register 2
req_rs3  in  RW  source register 3
req_use_rs3  in  1  rs3 needed
req_tag  in  TAG_WIDTH  request tag
gpr_rd_en  out  1  GPR read strobe
gpr_rd_addr  out  WW+RW  {wid, reg}
gpr_rd_data  in  NUM_THREADS*32  read data, valid exactly 1 cycle after gpr_rd_en
rsp_valid  out  1  collected operands valid
rsp_ready  in  1  consumer accepts
rsp_wid  out  WW  latched warp id
rsp_tag  out  TAG_WIDTH  latched tag
rs1_data  out  NUM_THREADS*32  operand 1
rs2_data  out  NUM_THREADS*32  operand 2
rs3_data  out  NUM_THREADS*32  operand 3

Behaviour:
- Clock is clk; reset is synchronous and active-high.
- States: IDLE, READ, CAPT, RSP.
- req_ready = (state==IDLE) && !reset. Combinational from state only.
- Accept in IDLE on req_valid&&req_ready:
  - Latch wid, tag and register indices.
  - Clear rs1/rs2/rs3_data to 0.
  - Build the needed-read list in order rs1, rs2, rs3 (rs3 only if req_use_rs3).
  - An operand whose index is 0 is omitted from the list and stays 0 (x0 = zero, no port access).
- N = number of needed reads (0..3).
  - N=0: IDLE -> RSP.
  - N>=1: IDLE -> READ.
- READ: each cycle assert gpr_rd_en with addr {wid, next needed reg}.
  - In the same cycle, capture gpr_rd_data into the operand read in the previous cycle, if any.
  - After issuing the last read -> CAPT.
- CAPT: capture the last operand, gpr_rd_en=0, -> RSP.
- RSP: rsp_valid=1. rsp_wid, rsp_tag and all data stay stable until rsp_ready. On handshake -> IDLE.
- Latency: accept at end of cycle T. rsp_valid first high in cycle T+2+N for N>=1, and T+1 for N=0.
- Minimum one IDLE cycle between responses: no accept in RSP.
- gpr_rd_addr is driven 0 whenever gpr_rd_en=0.
- Duplicate indices (e.g. rs1==rs2) are read twice; no deduplication.
- Unused rs3 (req_use_rs3=0) gives rs3_data=0.
- Reset values: state IDLE; rsp_valid, gpr_rd_en, gpr_rd_addr, rsp_wid, rsp_tag and all operand data are 0.
- Reset mid-operation (any state): abandon the request, return to IDLE, drop rsp_valid. Read data arriving the cycle after reset is ignored.
- rsp_ready while rsp_valid=0 is ignored.
- req_valid outside IDLE is not accepted; the requester must hold it.

Test Plan:
- wid=2, rs1=5, rs2=7, use_rs3=0, tag=0x3C, RAM returns per-lane patterns A,B:
  - rd_en at T+1 (addr {2,5}) and T+2 (addr {2,7}).
  - rsp_valid at T+4 with rs1=A, rs2=B, rs3=0, tag=0x3C.
- rs1=1, rs2=2, rs3=3, use_rs3=1: three consecutive rd_en, rsp_valid at T+5, each operand matches its address pattern.
- rs1=0, rs2=0, use_rs3=0: no rd_en; rsp_valid at T+1 with all data 0.
- rs1=0, rs2=9, use_rs3=1, rs3=0: a single read of {wid,9}; rsp_valid at T+3 with rs2 from reg 9 and rs1=rs3=0.
- Hold rsp_ready=0 for 5 cycles in RSP:
  - rsp_valid and data stay stable; req_ready=0 throughout.
  - After the handshake, req_ready=1 next cycle and a second request completes correctly.
- Assert reset in READ after the first rd_en:
  - Next cycle state is IDLE, rsp_valid=0, rd_en=0.
  - A new request then yields correct data, unaffected by the aborted read.
